inst_fetch: RTL and testbench

Instruction-fetch stage of the MIPS16 pipeline. It holds the program counter and drives the combinational instruction ROM: it sends `ce`/`addr` and takes back `inst`. The fetched word is latched into the IF/ID pipeline register for the decoder. It handles four events: pipeline stalls, delayed-branch redirects, exception/interrupt flushes, and the structural conflict when MEM uses the shared instruction/data bus.

---
 rtl/cpu_defs.sv | 32 +++
 rtl/pc_reg.sv | 73 +++++++
 rtl/inst_fetch.sv | 99 +++++++++
 tb/tb_inst_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Package     : cpu_defs
// Description : Shared constants and types for the MIPS16 fetch stage.
//               Word/address width, reset PC, bubble instruction and the
//               fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

  // Instruction words and addresses share one width on this core.
  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  // First address fetched once the core leaves reset.
  localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;

  // MIPS16 NOP, written into IF/ID whenever a bubble is inserted.
  localparam logic [WORD_W-1:0] NOP_INST = 16'h0800;

  // Fetch FSM encoding.
  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Sequential successor; 16'hFFFF rolls over to 16'h0000 by natural wrap.
  function automatic word_t next_seq_pc(input word_t pc);
    return pc + word_t'(1);
  endfunction

endpackage : cpu_defs
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program-counter register, BOOT/RUN FSM and next-PC priority
//               mux of the instruction-fetch stage.
// Ports       : clk, rst (async, active-low)
//               stall_pc_i, branch_flag_i, branch_target_i, flush_i,
//               flush_pc_i, mem_conflict_i  - redirect / hold controls
//               pc_o      - current PC (drives the ROM address)
//               rom_ce_o  - ROM enable
//               boot_o    - high during the single post-reset BOOT cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc_i,
  input  logic              branch_flag_i,
  input  logic [WORD_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [WORD_W-1:0] flush_pc_i,
  input  logic              mem_conflict_i,
  output logic [WORD_W-1:0] pc_o,
  output logic              rom_ce_o,
  output logic              boot_o
);

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;

  // BOOT is a one-cycle hold after reset release; RUN is absorbing.
  always_comb begin
    state_d = ST_RUN;
  end

  // Next PC. Flush outranks everything, including BOOT, so an exception
  // raised in the very first cycle still redirects. A conflict cycle holds
  // the PC so the address that lost the bus is refetched next cycle.
  always_comb begin
    pc_d = next_seq_pc(pc_q);
    if (flush_i) begin
      pc_d = flush_pc_i;
    end else if (state_q == ST_BOOT) begin
      pc_d = pc_q;
    end else if (stall_pc_i) begin
      pc_d = pc_q;
    end else if (branch_flag_i) begin
      pc_d = branch_target_i;
    end else if (mem_conflict_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_o     = pc_q;
  assign boot_o   = (state_q == ST_BOOT);
  assign rom_ce_o = (state_q == ST_RUN) && !mem_conflict_i && !flush_i;

endmodule : pc_reg
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : MIPS16 instruction-fetch stage. Holds the PC, drives the
//               combinational instruction ROM and latches the fetched word
//               into the IF/ID pipeline register.
// Ports       : clk, rst (async, active-low)
//               stall_pc, stall_id          - hazard-unit holds
//               branch_flag, branch_target  - delayed-branch redirect
//               flush, flush_pc             - exception/interrupt redirect
//               mem_conflict                - MEM owns the shared bus
//               rom_ce, rom_addr, rom_inst  - instruction ROM interface
//               id_pc, id_inst, id_valid    - IF/ID register contents
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc,
  input  logic              stall_id,
  input  logic              branch_flag,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  input  logic              mem_conflict,
  output logic              rom_ce,
  output logic [WORD_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_inst,
  output logic [WORD_W-1:0] id_pc,
  output logic [WORD_W-1:0] id_inst,
  output logic              id_valid
);

  logic [WORD_W-1:0] pc;
  logic              boot;

  logic [WORD_W-1:0] id_pc_q;
  logic [WORD_W-1:0] id_pc_d;
  logic [WORD_W-1:0] id_inst_q;
  logic [WORD_W-1:0] id_inst_d;
  logic              id_valid_q;
  logic              id_valid_d;

  pc_reg u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .stall_pc_i      (stall_pc),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .flush_i         (flush),
    .flush_pc_i      (flush_pc),
    .mem_conflict_i  (mem_conflict),
    .pc_o            (pc),
    .rom_ce_o        (rom_ce),
    .boot_o          (boot)
  );

  assign rom_addr = pc;

  // IF/ID next value. A taken branch deliberately does not appear here:
  // the word fetched alongside it is the delay slot and must be kept.
  always_comb begin
    id_pc_d    = pc;
    id_inst_d  = rom_inst;
    id_valid_d = 1'b1;
    if (flush) begin
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (stall_id) begin
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
    end else if (boot || stall_pc || mem_conflict) begin
      // No fetch this cycle; tag the bubble with the PC it stands in for.
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch. Stimulus drives directed
//               and random cycles, a behavioural model predicts the IF/ID
//               contents after each edge and queues them; a monitor pops and
//               compares after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  localparam int NOP = 'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_pc = 1'b0;
  logic        stall_id = 1'b0;
  logic        branch_flag = 1'b0;
  logic [15:0] branch_target = '0;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = '0;
  logic        mem_conflict = 1'b0;
  logic        rom_ce;
  logic [15:0] rom_addr;
  logic [15:0] rom_inst;
  logic [15:0] id_pc;
  logic [15:0] id_inst;
  logic        id_valid;

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall_pc      (stall_pc),
    .stall_id      (stall_id),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .mem_conflict  (mem_conflict),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid)
  );

  always #5 clk = ~clk;

  // ROM contents: word n holds 16'h4000 + n.
  assign rom_inst = 16'h4000 + rom_addr;

  function automatic int rom_word(input int a);
    return (a + 'h4000) & 'hFFFF;
  endfunction

  typedef struct {
    bit valid;
    bit pc_known;
    int pc;
    int inst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: PC, whether the boot cycle is over, IF/ID view.
  int   mpc;
  bit   mrun;
  exp_t mid;

  bit mon_en = 1'b0;
  bit armed  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one queued expectation per rising edge while enabled.
  always @(posedge clk) armed = mon_en && (sb.size() != 0);

  always @(negedge clk) begin
    if (armed) begin
      exp_t e;
      armed = 1'b0;
      e = sb.pop_front();
      check("id_valid", int'(id_valid), int'(e.valid));
      check("id_inst", int'(id_inst), e.inst);
      if (e.pc_known) check("id_pc", int'(id_pc), e.pc);
    end
  end

  // Called at posedge+1: drives one cycle, predicts, checks ROM interface.
  task automatic run_cycle(input bit sp, input bit sid, input bit bf,
                           input logic [15:0] bt, input bit fl,
                           input logic [15:0] fp, input bit mc);
    bit exp_ce;
    stall_pc      = sp;
    stall_id      = sid;
    branch_flag   = bf;
    branch_target = bt;
    flush         = fl;
    flush_pc      = fp;
    mem_conflict  = mc;

    // The ROM is enabled only once booted, with the bus free and no flush.
    exp_ce = mrun && !mc && !fl;

    // What IF/ID should hold after the coming edge.
    if (fl) begin
      mid = '{valid: 1'b0, pc_known: 1'b0, pc: 0, inst: NOP};
    end else if (sid) begin
      // contents frozen
    end else if (exp_ce && !sp) begin
      mid = '{valid: 1'b1, pc_known: 1'b1, pc: mpc, inst: rom_word(mpc)};
    end else begin
      mid = '{valid: 1'b0, pc_known: 1'b1, pc: mpc, inst: NOP};
    end
    sb.push_back(mid);

    @(negedge clk);
    check("rom_ce", int'(rom_ce), int'(exp_ce));
    check("rom_addr", int'(rom_addr), mpc);

    // Where the PC goes next.
    if (fl)                mpc = int'(fp);
    else if (!mrun || sp)  mpc = mpc;
    else if (bf)           mpc = int'(bt);
    else if (mc)           mpc = mpc;
    else                   mpc = (mpc + 1) % 65536;
    mrun = 1'b1;

    @(posedge clk);
    #1;
  endtask

  task automatic clean(input int n);
    for (int k = 0; k < n; k++) run_cycle(0, 0, 0, 16'h0, 0, 16'h0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_ce"},   int'(rom_ce),   0);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
    check({tag, "_id_pc"},    int'(id_pc),    0);
    check({tag, "_id_inst"},  int'(id_inst),  NOP);
    check({tag, "_id_valid"}, int'(id_valid), 0);
  endtask

  // Asserts reset away from the clock edge, checks it acts immediately,
  // then releases at posedge+1 ready for run_cycle.
  task automatic do_reset(input string tag);
    mon_en = 1'b0;
    @(negedge clk);
    #1;
    rst           = 1'b0;
    stall_pc      = 1'b0;
    stall_id      = 1'b0;
    branch_flag   = 1'b0;
    flush         = 1'b0;
    mem_conflict  = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    rst    = 1'b1;
    mpc    = 0;
    mrun   = 1'b0;
    mid    = '{valid: 1'b0, pc_known: 1'b1, pc: 0, inst: NOP};
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bit          hold_br;
    logic [15:0] held_bt;
    hold_br = 1'b0;
    held_bt = '0;

    repeat (2) @(posedge clk);
    do_reset("rst0");

    // Boot, then sequential fetch up to pc 5.
    for (int k = 0; k < 20 && !(mrun && mpc == 5); k++) clean(1);
    // Branch in ID while fetching pc 5 (delay slot), then 0x20, 0x21.
    run_cycle(0, 0, 1, 16'h0020, 0, 16'h0, 0);
    clean(2);

    // Two conflict cycles at pc 8, then refetch of 8 without a skip.
    run_cycle(0, 0, 0, 16'h0, 1, 16'h0007, 0);
    clean(1);
    run_cycle(0, 0, 0, 16'h0, 0, 16'h0, 1);
    run_cycle(0, 0, 0, 16'h0, 0, 16'h0, 1);
    clean(2);

    // Three stalled cycles with a held branch, applied when released.
    for (int k = 0; k < 3; k++) run_cycle(1, 1, 1, 16'h0040, 0, 16'h0, 0);
    run_cycle(0, 0, 1, 16'h0040, 0, 16'h0, 0);
    clean(2);

    // Flush during a stall.
    run_cycle(1, 1, 0, 16'h0, 1, 16'h0100, 0);
    clean(2);

    // Wrap from 16'hFFFF to 16'h0000.
    run_cycle(0, 0, 0, 16'h0, 1, 16'hFFFE, 0);
    clean(4);

    // Random traffic obeying the hazard-unit rules.
    for (int i = 0; i < 2000; i++) begin
      bit          sp, sid, bf, fl, mc;
      logic [15:0] bt, fp;
      sp  = ($urandom_range(5) == 0);
      sid = sp && ($urandom_range(1) == 1);
      if (hold_br) begin
        bf = 1'b1;
        bt = held_bt;
      end else begin
        bf = ($urandom_range(7) == 0);
        bt = 16'($urandom);
      end
      fl = ($urandom_range(19) == 0);
      fp = 16'($urandom);
      mc = ($urandom_range(7) == 0);
      hold_br = bf && sp && !fl;
      held_bt = bt;
      run_cycle(sp, sid, bf, bt, fl, fp, mc);
    end

    // Reset mid-run, then a fresh BOOT cycle and sequential fetch.
    do_reset("rst1");
    clean(4);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_inst_fetch
`default_nettype wire
